// File: rtl/lfsr_range_rand.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : lfsr_range_rand
//  Description : Configurable-width Fibonacci LFSR with runtime reseeding and
//                all-zero lockup recovery, plus a request/response engine
//                that returns unbiased values in [0, limit-1] by rejection
//                sampling with a bounded number of attempts.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_range_rand #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int               OUT_W     = 11,
    parameter int               MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             seed_load_i,
    input  logic [WIDTH-1:0] seed_in_i,
    output logic [WIDTH-1:0] rnd_o,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [OUT_W-1:0] limit_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] value_o,
    output logic             fallback_o
);

    // Try counter only has to reach MAX_TRIES-1.
    localparam int               TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] rnd_q;
    logic [WIDTH-1:0] rnd_d;
    logic [WIDTH-1:0] lfsr_step;
    logic [OUT_W-1:0] limit_q;
    logic [TRY_W-1:0] tries_q;
    logic [OUT_W-1:0] value_q;
    logic             fallback_q;
    logic             out_valid_q;

    // Candidate evaluation terms, all unsigned at OUT_W bits.
    logic [OUT_W-1:0] cand;
    logic             cand_in_range;
    logic [OUT_W-1:0] cand_diff;
    logic [OUT_W-1:0] fold_value;

    // Next LFSR state: seed load beats lockup recovery beats stepping.
    always_comb begin
        lfsr_step = {rnd_q[WIDTH-2:0], ^(rnd_q & TAPS)};
        rnd_d     = rnd_q;
        if (seed_load_i) begin
            // A zero seed would lock the register up, so fall back to SEED.
            rnd_d = (seed_in_i == '0) ? SEED : seed_in_i;
        end else if (rnd_q == '0) begin
            rnd_d = SEED;
        end else if (enable_i || (state_q == S_DRAW)) begin
            rnd_d = lfsr_step;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rnd_q <= SEED;
        end else begin
            rnd_q <= rnd_d;
        end
    end

    // Candidate tests; the fold value is only consumed when cand >= limit_q.
    always_comb begin
        cand          = rnd_q[OUT_W-1:0];
        cand_in_range = (cand < limit_q);
        cand_diff     = cand - limit_q;
        fold_value    = (cand_diff < limit_q) ? cand_diff : (limit_q - OUT_W'(1));
    end

    // Request engine: accept, draw until in range or out of tries, present.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            limit_q     <= '0;
            tries_q     <= '0;
            value_q     <= '0;
            fallback_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        limit_q <= limit_i;
                        tries_q <= '0;
                        state_q <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (limit_q == '0) begin
                        // Empty range: nothing can be drawn, report fallback.
                        value_q    <= '0;
                        fallback_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else if (cand_in_range) begin
                        value_q    <= cand;
                        fallback_q <= 1'b0;
                        state_q    <= S_DONE;
                    end else if (tries_q == LAST_TRY) begin
                        value_q    <= fold_value;
                        fallback_q <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        // LFSR steps this cycle, giving a fresh candidate.
                        tries_q <= tries_q + TRY_W'(1);
                    end
                end
                S_DONE: begin
                    // First DONE cycle raises out_valid from registered result;
                    // it then holds until the consumer takes it.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rnd_o       = rnd_q;
    assign req_ready_o = (state_q == S_IDLE);
    assign out_valid_o = out_valid_q;
    assign value_o     = value_q;
    assign fallback_o  = fallback_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_range_rand.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_range_rand
//  Description : Scoreboard bench for lfsr_range_rand with a transaction-level
//                reference model of the LFSR sequence and rejection sampler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_range_rand;

    localparam int          W         = 16;
    localparam int          OW        = 11;
    localparam int          MAX_TRIES = 8;
    localparam logic [15:0] TAPS_M    = 16'hB400;
    localparam logic [15:0] SEED_M    = 16'hACE1;

    logic          clk;
    logic          reset;
    logic          enable_i;
    logic          seed_load_i;
    logic [W-1:0]  seed_in_i;
    logic [W-1:0]  rnd_o;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [OW-1:0] limit_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [OW-1:0] value_o;
    logic          fallback_o;

    lfsr_range_rand dut (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable_i),
        .seed_load_i (seed_load_i),
        .seed_in_i   (seed_in_i),
        .rnd_o       (rnd_o),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .limit_i     (limit_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .value_o     (value_o),
        .fallback_o  (fallback_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit fb;
        int appear;
    } exp_t;

    exp_t sbq[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_accept = 0;
    int resp_cnt = 0;
    int fb_cnt   = 0;

    // Reference model state (transaction-level view of the DUT)
    logic [15:0] m_rnd     = SEED_M;
    bit          m_idle    = 1'b1;
    int          draw_left = 0;
    bit          pend      = 1'b0;
    bit          m_valid   = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One LFSR step from the polynomial: feedback is the parity of tapped bits.
    function automatic logic [15:0] model_step(input logic [15:0] r);
        bit fbk;
        fbk = 1'b0;
        for (int i = 0; i < 16; i++)
            if (TAPS_M[i]) fbk = fbk ^ r[i];
        return {r[14:0], fbk};
    endfunction

    // Rejection sampling on the candidate stream starting at r0.
    function automatic void model_draw(input logic [15:0] r0, input int lim,
                                       output int val, output bit fb, output int n);
        logic [15:0] r;
        int c;
        r   = r0;
        val = 0;
        fb  = 1'b0;
        n   = 0;
        for (int k = 0; k < MAX_TRIES; k++) begin
            c = int'(r) % (1 << OW);
            n = k + 1;
            if (lim == 0) begin
                val = 0; fb = 1'b1; return;
            end
            if (c < lim) begin
                val = c; fb = 1'b0; return;
            end
            if (k == MAX_TRIES - 1) begin
                fb  = 1'b1;
                val = ((c - lim) < lim) ? (c - lim) : (lim - 1);
                return;
            end
            r = model_step(r);
        end
    endfunction

    // Advance one clock, update the model from the inputs seen at the edge.
    task automatic tick();
        logic        rst, en, sl, rv, forced;
        logic [15:0] si;
        int          lim, v, n;
        bit          f;
        rst = reset; en = enable_i; sl = seed_load_i; si = seed_in_i;
        rv  = req_valid_i; lim = int'(limit_i);
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            m_rnd = SEED_M; m_idle = 1'b1; draw_left = 0; pend = 1'b0; m_valid = 1'b0;
            sbq.delete();
        end else begin
            forced = (draw_left > 0);
            if (sl)                m_rnd = (si == 16'h0) ? SEED_M : si;
            else if (m_rnd == 0)   m_rnd = SEED_M;
            else if (en || forced) m_rnd = model_step(m_rnd);
            if (m_idle) begin
                if (rv) begin
                    model_draw(m_rnd, lim, v, f, n);
                    sbq.push_back('{v, f, cyc + n + 1});
                    draw_left = n;
                    m_idle    = 1'b0;
                    n_accept++;
                end
            end else if (draw_left > 0) begin
                draw_left--;
                if (draw_left == 0) pend = 1'b1;
            end else if (pend) begin
                pend    = 1'b0;
                m_valid = 1'b1;
            end else if (m_valid && (sl | 1'b1) && out_ready_i_at_edge(rst)) begin
                m_valid = 1'b0;
                m_idle  = 1'b1;
            end
        end
        check("rnd", rnd_o, m_rnd);
        check("req_ready", req_ready_o, m_idle);
        check("out_valid", out_valid_o, m_valid);
    endtask

    // out_ready as it was sampled at the last edge (held by the driver).
    logic ord_edge;
    function automatic bit out_ready_i_at_edge(input logic unused_rst);
        return ord_edge & ~unused_rst;
    endfunction
    always @(posedge clk) ord_edge <= out_ready_i;

    // Monitor: pop expected response on each new out_valid, then watch stability.
    initial begin : monitor
        exp_t cur;
        bit   have_cur;
        have_cur = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                have_cur = 1'b0;
            end else if (out_valid_o) begin
                if (!have_cur) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_valid", out_valid_o, 0);
                    end else begin
                        cur      = sbq.pop_front();
                        have_cur = 1'b1;
                        resp_cnt++;
                        if (fallback_o) fb_cnt++;
                        check("value", value_o, cur.val);
                        check("fallback", fallback_o, cur.fb);
                        check("latency", cyc, cur.appear);
                    end
                end else begin
                    check("value_stable", value_o, cur.val);
                    check("fallback_stable", fallback_o, cur.fb);
                end
                if (out_ready_i) have_cur = 1'b0;
            end
        end
    end

    // Issue `count` requests; lim_fixed < 0 means a random limit per request.
    task automatic run_requests(input int count, input int lim_fixed, input bit rand_ready);
        int target, guard;
        target = n_accept + count;
        guard  = 0;
        while ((n_accept < target || !m_idle) && guard < count * 40) begin
            req_valid_i = m_idle && (n_accept < target);
            if (req_valid_i && lim_fixed >= 0) limit_i = OW'(lim_fixed);
            else                               limit_i = OW'($urandom_range(0, (1 << OW) - 1));
            out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            enable_i    = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        check("requests_done", n_accept, target);
        req_valid_i = 1'b0;
        out_ready_i = 1'b1;
        enable_i    = 1'b0;
    endtask

    initial begin : watchdog
        #3_000_000;
        errors++;
        $display("FAIL timeout reached at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "simulation timeout");
    end

    initial begin : driver
        int resp0, fb0;
        reset = 1'b1; enable_i = 1'b0; seed_load_i = 1'b0; seed_in_i = '0;
        req_valid_i = 1'b0; limit_i = '0; out_ready_i = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_rnd", rnd_o, 16'hACE1);
        check("reset_value", value_o, 0);
        check("reset_fallback", fallback_o, 0);

        // Single step and full period
        enable_i = 1'b1;
        tick();
        check("first_step", rnd_o, 16'h59C3);
        for (int i = 0; i < 65534; i++) begin
            tick();
            if (rnd_o == 16'h0) check("nonzero", rnd_o, 1);
        end
        check("period", rnd_o, 16'hACE1);

        // Reseeding
        tick();
        enable_i = 1'b0; seed_load_i = 1'b1; seed_in_i = 16'h0000;
        tick();
        check("seed_zero", rnd_o, 16'hACE1);
        enable_i = 1'b1; seed_in_i = 16'h1234;
        tick();
        check("seed_load_wins", rnd_o, 16'h1234);
        seed_load_i = 1'b0; enable_i = 1'b0;

        // limit = 1200, back-to-back, consumer always ready
        resp0 = resp_cnt; fb0 = fb_cnt;
        run_requests(1000, 1200, 1'b0);
        check("fallback_rate_ok", ((fb_cnt - fb0) * 100 < (resp_cnt - resp0)), 1);

        // Boundary limits
        run_requests(4, 0, 1'b0);
        run_requests(20, 1, 1'b0);
        run_requests(10, 2047, 1'b1);

        // Random limits with random backpressure
        run_requests(200, -1, 1'b1);

        // Held backpressure with an ignored request pulse
        out_ready_i = 1'b0; req_valid_i = 1'b1; limit_i = OW'(1200);
        tick();
        req_valid_i = 1'b0;
        for (int i = 0; i < 20 && !m_valid; i++) tick();
        check("bp_valid", out_valid_o, 1);
        for (int i = 0; i < 5; i++) begin
            req_valid_i = (i == 2);
            limit_i     = OW'($urandom_range(0, 2047));
            tick();
            check("bp_req_ready", req_ready_o, 0);
        end
        req_valid_i = 1'b0; out_ready_i = 1'b1;
        tick();
        check("bp_release_ready", req_ready_o, 1);
        check("bp_release_valid", out_valid_o, 0);

        // Reset while drawing
        req_valid_i = 1'b1; limit_i = OW'(1200);
        tick();
        req_valid_i = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_draw_ready", req_ready_o, 1);
        check("rst_draw_valid", out_valid_o, 0);
        check("rst_draw_rnd", rnd_o, 16'hACE1);
        tick();
        tick();

        check("scoreboard_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_range_rand.md
Name: lfsr_range_rand

Overview:
Parametrised successor to the fixed 16-bit food-placement LFSR. It provides a configurable-width Fibonacci LFSR with runtime reseeding and all-zero lockup recovery. A request/response engine on top returns uniformly distributed values in [0, limit-1] by rejection sampling. The game FSM uses it to pick a food cell index (e.g. limit = 1200 for a 40x30 grid) without modulo bias.

Parameters:
WIDTH, 16, LFSR state width (8..32)
TAPS, 16'hB400, feedback tap mask; bit i set means state[i] is XORed into the feedback (default = x^16+x^14+x^13+x^11)
SEED, 16'hACE1, reset/reload value; must be non-zero
OUT_W, 11, width of limit and result (OUT_W <= WIDTH)
MAX_TRIES, 8, rejection attempts before fallback (>= 1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
enable  in  1  free-run step of LFSR when idle
seed_load  in  1  load seed_in into LFSR this cycle
seed_in  in  WIDTH  new seed
rnd  out  WIDTH  current LFSR state (registered)
req_valid  in  1  request a ranged value
req_ready  out  1  high only in IDLE
limit  in  OUT_W  exclusive upper bound, sampled on request accept
out_valid  out  1  result available, held until out_ready
out_ready  in  1  consumer accepts result
value  out  OUT_W  result, stable while out_valid
fallback  out  1  result came from fallback path, valid with out_valid

Behaviour:
- Reset (clk edge with reset=1): rnd=SEED, state IDLE, out_valid=0, value=0, fallback=0, try counter=0. Reset overrides every other input and aborts any draw in progress.
- LFSR step: rnd <= {rnd[WIDTH-2:0], ^(rnd & TAPS)}.
- LFSR update priority, highest first:
  - seed_load: rnd <= seed_in, or SEED if seed_in==0.
  - Lockup: if rnd==0, rnd <= SEED.
  - Step, when enable==1 or state==DRAW.
  - Otherwise hold.
- FSM states IDLE, DRAW, DONE:
  - IDLE: req_ready=1. On req_valid, latch limit_q=limit, clear the try counter, go to DRAW.
  - DRAW: candidate = rnd[OUT_W-1:0] (registered state).
    - limit_q==0: value=0, fallback=1, go to DONE.
    - candidate < limit_q: value=candidate, fallback=0, go to DONE.
    - Otherwise, if tries == MAX_TRIES-1: fallback=1, go to DONE, with value = candidate-limit_q if (candidate-limit_q) < limit_q, else limit_q-1.
    - Otherwise tries++ and stay in DRAW (the LFSR steps, giving a new candidate next cycle).
  - DONE: out_valid=1, value/fallback held. On out_ready, go to IDLE (out_valid drops next cycle). LFSR steps only if enable.
- Latency: request accepted at edge T; first DRAW evaluation in cycle T+1; out_valid asserted at earliest from edge T+2. Worst case is T+1+MAX_TRIES.
- Only one outstanding request. req_ready=0 in DRAW and DONE, and req_valid is ignored there.
- limit changes after acceptance have no effect (limit_q is used).
- seed_load during DRAW: the current cycle still evaluates the registered candidate; the next candidate comes from the loaded seed.
- Width rules: the comparison is unsigned at OUT_W bits; the subtraction is unsigned OUT_W bits and only evaluated when candidate >= limit_q.
- Sequence, defaults: period 2^16-1; rnd is never 0 unless forced by a bad TAPS value, which triggers lockup recovery.

Test Plan:
- Reset with defaults -> rnd=16'hACE1. enable=1 for one cycle -> rnd=16'h59C3. Free-run 65535 steps -> rnd returns to 16'hACE1 and is never 0 in between.
- seed_load=1, seed_in=0 -> rnd=16'hACE1 next cycle. seed_in=16'h1234 -> rnd=16'h1234. With enable=1 and seed_load in the same cycle, the load wins.
- limit=1200, 1000 back-to-back requests with out_ready=1 -> every value < 1200. Earliest out_valid is exactly 2 cycles after accept. fallback rate is < 1% of responses.
- limit=0 -> out_valid at accept+2, value=0, fallback=1. limit=1 -> value=0 on every response.
- Backpressure: out_ready=0 for 5 cycles -> out_valid, value and fallback stable; req_ready=0; a req_valid pulse is ignored. out_ready=1 -> IDLE next cycle.
- reset=1 while in DRAW -> next cycle: IDLE, out_valid=0, rnd=16'hACE1, req_ready=1.
